decode_stage: RTL and testbench

Parametrised, pipelined RV32I instruction decode stage with a valid/ready handshake on both sides, a 2-entry skid buffer, sign-extended immediates for all six base formats, illegal-opcode detection, flush and a delivered-instruction counter. It sits between the fetch stage (upstream) and the register-read/execute stage (downstream) and replaces the single-register, enable-driven decoder.

---
 rtl/decode_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the incoming word, registered
// into a 2-entry (output + skid) buffer with valid/ready on both sides.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int SIGN_EXT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             I_valid,
  output logic             O_ready,
  input  logic [31:0]      I_instr,
  input  logic [XLEN-1:0]  I_pc,
  input  logic             I_flush,
  output logic             O_valid,
  input  logic             I_ready,
  output logic [6:0]       O_op,
  output logic [4:0]       O_rd,
  output logic [4:0]       O_rs1,
  output logic [4:0]       O_rs2,
  output logic [2:0]       O_funct3,
  output logic [6:0]       O_funct7,
  output logic [XLEN-1:0]  O_imm,
  output logic [2:0]       O_fmt,
  output logic             O_branch,
  output logic             O_jump,
  output logic             O_mread,
  output logic             O_load,
  output logic             O_mwrite,
  output logic             O_regwrite,
  output logic             O_illegal,
  output logic [XLEN-1:0]  O_pc,
  output logic [CNT_W-1:0] O_count
);

  typedef struct packed {
    logic [6:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            branch;
    logic            jump;
    logic            mread;
    logic            load;
    logic            mwrite;
    logic            regwrite;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
                         FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5;

  // Widen an immediate whose top bit sits at raw[msb]; force_sign keeps
  // U-type sign-extended on 64-bit datapaths even in zero-fill mode.
  function automatic logic [XLEN-1:0] ext_imm(input logic [31:0] raw,
                                              input logic [4:0]  msb,
                                              input logic        force_sign);
    logic [XLEN-1:0] hi;
    logic            s;
    hi = {XLEN{1'b1}} << ({1'b0, msb} + 6'd1);
    s  = raw[msb] & ((SIGN_EXT != 0) | force_sign);
    return (XLEN'(raw) & ~hi) | (s ? hi : '0);
  endfunction

  entry_t     dec_p0;
  entry_t     out_p1, skid_p1;
  logic       vld_p1, skid_vld_p1;
  logic [CNT_W-1:0] cnt_p1;
  state_t     state_q, state_d;
  logic       accept, deliver;
  logic       load_out_dec, load_out_skid, load_skid;

  // Stage p0: decode of the word on the input port. Matching the full 7-bit
  // opcode also rejects any word whose low two bits are not 2'b11.
  always_comb begin
    dec_p0        = '0;
    dec_p0.op     = I_instr[6:0];
    dec_p0.rd     = I_instr[11:7];
    dec_p0.rs1    = I_instr[19:15];
    dec_p0.rs2    = I_instr[24:20];
    dec_p0.funct3 = I_instr[14:12];
    dec_p0.pc     = I_pc;
    case (I_instr[6:0])
      7'b0110011: begin
        dec_p0.fmt      = FMT_R;
        dec_p0.funct7   = I_instr[31:25];
        dec_p0.regwrite = 1'b1;
      end
      7'b0010011: begin
        dec_p0.fmt      = FMT_I;
        dec_p0.imm      = ext_imm({20'b0, I_instr[31:20]}, 5'd11, 1'b0);
        dec_p0.funct7   = (I_instr[13:12] == 2'b01) ? I_instr[31:25] : 7'b0;
        dec_p0.regwrite = 1'b1;
      end
      7'b0000011: begin
        dec_p0.fmt      = FMT_I;
        dec_p0.imm      = ext_imm({20'b0, I_instr[31:20]}, 5'd11, 1'b0);
        dec_p0.mread    = 1'b1;
        dec_p0.load     = 1'b1;
        dec_p0.regwrite = 1'b1;
      end
      7'b0100011: begin
        dec_p0.fmt    = FMT_S;
        dec_p0.imm    = ext_imm({20'b0, I_instr[31:25], I_instr[11:7]}, 5'd11, 1'b0);
        dec_p0.mwrite = 1'b1;
      end
      7'b1100011: begin
        dec_p0.fmt    = FMT_B;
        dec_p0.imm    = ext_imm({19'b0, I_instr[31], I_instr[7], I_instr[30:25],
                                 I_instr[11:8], 1'b0}, 5'd12, 1'b0);
        dec_p0.branch = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        dec_p0.fmt      = FMT_U;
        dec_p0.imm      = ext_imm({I_instr[31:12], 12'b0}, 5'd31, 1'b1);
        dec_p0.regwrite = 1'b1;
      end
      7'b1101111: begin
        dec_p0.fmt      = FMT_J;
        dec_p0.imm      = ext_imm({11'b0, I_instr[31], I_instr[19:12], I_instr[20],
                                   I_instr[30:21], 1'b0}, 5'd20, 1'b0);
        dec_p0.jump     = 1'b1;
        dec_p0.regwrite = 1'b1;
      end
      7'b1100111: begin
        dec_p0.fmt      = FMT_I;
        dec_p0.imm      = ext_imm({20'b0, I_instr[31:20]}, 5'd11, 1'b0);
        dec_p0.jump     = 1'b1;
        dec_p0.regwrite = 1'b1;
      end
      default: begin
        dec_p0.illegal = 1'b1;
        dec_p0.funct7  = I_instr[31:25];
      end
    endcase
  end

  // Ready depends only on buffer occupancy and reset, never on I_valid.
  assign O_ready = !rst && !skid_vld_p1;
  assign accept  = I_valid && O_ready;
  assign deliver = vld_p1 && I_ready;

  // Buffer occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next occupancy and buffer load selects; flush overrides everything.
  always_comb begin
    state_d       = state_q;
    load_out_dec  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (I_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d      = ONE;
          load_out_dec = 1'b1;
        end
        ONE: begin
          if (accept && deliver) begin
            load_out_dec = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (deliver) begin
            state_d = EMPTY;
          end
        end
        FULL: if (deliver) begin
          state_d       = ONE;
          load_out_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Stage p1: output and skid registers plus delivered-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p1      <= '0;
      skid_p1     <= '0;
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      cnt_p1      <= '0;
    end else begin
      vld_p1      <= (state_d != EMPTY);
      skid_vld_p1 <= (state_d == FULL);
      cnt_p1      <= cnt_p1 + {{(CNT_W-1){1'b0}}, deliver};
      if (load_out_dec)  out_p1  <= dec_p0;
      if (load_out_skid) out_p1  <= skid_p1;
      if (load_skid)     skid_p1 <= dec_p0;
    end
  end

  assign O_valid    = vld_p1;
  assign O_count    = cnt_p1;
  assign O_op       = out_p1.op;
  assign O_rd       = out_p1.rd;
  assign O_rs1      = out_p1.rs1;
  assign O_rs2      = out_p1.rs2;
  assign O_funct3   = out_p1.funct3;
  assign O_funct7   = out_p1.funct7;
  assign O_imm      = out_p1.imm;
  assign O_fmt      = out_p1.fmt;
  assign O_branch   = out_p1.branch;
  assign O_jump     = out_p1.jump;
  assign O_mread    = out_p1.mread;
  assign O_load     = out_p1.load;
  assign O_mwrite   = out_p1.mwrite;
  assign O_regwrite = out_p1.regwrite;
  assign O_illegal  = out_p1.illegal;
  assign O_pc       = out_p1.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a default instance, a zero-fill instance
// and a 4-bit-counter instance all driven from the same stimulus.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, I_valid, I_flush, I_ready;
  logic [31:0] I_instr, I_pc;

  logic        O_ready, O_valid;
  logic [6:0]  O_op, O_funct7;
  logic [4:0]  O_rd, O_rs1, O_rs2;
  logic [2:0]  O_funct3, O_fmt;
  logic [31:0] O_imm, O_pc;
  logic        O_branch, O_jump, O_mread, O_load, O_mwrite, O_regwrite, O_illegal;
  logic [15:0] O_count;

  logic        z_ready, z_valid;
  logic [6:0]  z_op, z_funct7;
  logic [4:0]  z_rd, z_rs1, z_rs2;
  logic [2:0]  z_funct3, z_fmt;
  logic [31:0] z_imm, z_pc;
  logic        z_branch, z_jump, z_mread, z_load, z_mwrite, z_regwrite, z_illegal;
  logic [15:0] z_count;

  logic        w_ready, w_valid;
  logic [6:0]  w_op, w_funct7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_funct3, w_fmt;
  logic [31:0] w_imm, w_pc;
  logic        w_branch, w_jump, w_mread, w_load, w_mwrite, w_regwrite, w_illegal;
  logic [3:0]  w_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SIGN_EXT(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .I_valid(I_valid), .O_ready(O_ready), .I_instr(I_instr),
    .I_pc(I_pc), .I_flush(I_flush), .O_valid(O_valid), .I_ready(I_ready),
    .O_op(O_op), .O_rd(O_rd), .O_rs1(O_rs1), .O_rs2(O_rs2), .O_funct3(O_funct3),
    .O_funct7(O_funct7), .O_imm(O_imm), .O_fmt(O_fmt), .O_branch(O_branch),
    .O_jump(O_jump), .O_mread(O_mread), .O_load(O_load), .O_mwrite(O_mwrite),
    .O_regwrite(O_regwrite), .O_illegal(O_illegal), .O_pc(O_pc), .O_count(O_count));

  decode_stage #(.XLEN(32), .SIGN_EXT(0), .CNT_W(16)) dut_z (
    .clk(clk), .rst(rst), .I_valid(I_valid), .O_ready(z_ready), .I_instr(I_instr),
    .I_pc(I_pc), .I_flush(I_flush), .O_valid(z_valid), .I_ready(I_ready),
    .O_op(z_op), .O_rd(z_rd), .O_rs1(z_rs1), .O_rs2(z_rs2), .O_funct3(z_funct3),
    .O_funct7(z_funct7), .O_imm(z_imm), .O_fmt(z_fmt), .O_branch(z_branch),
    .O_jump(z_jump), .O_mread(z_mread), .O_load(z_load), .O_mwrite(z_mwrite),
    .O_regwrite(z_regwrite), .O_illegal(z_illegal), .O_pc(z_pc), .O_count(z_count));

  decode_stage #(.XLEN(32), .SIGN_EXT(1), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .I_valid(I_valid), .O_ready(w_ready), .I_instr(I_instr),
    .I_pc(I_pc), .I_flush(I_flush), .O_valid(w_valid), .I_ready(I_ready),
    .O_op(w_op), .O_rd(w_rd), .O_rs1(w_rs1), .O_rs2(w_rs2), .O_funct3(w_funct3),
    .O_funct7(w_funct7), .O_imm(w_imm), .O_fmt(w_fmt), .O_branch(w_branch),
    .O_jump(w_jump), .O_mread(w_mread), .O_load(w_load), .O_mwrite(w_mwrite),
    .O_regwrite(w_regwrite), .O_illegal(w_illegal), .O_pc(w_pc), .O_count(w_count));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    I_valid = 1'b1;
    I_instr = instr;
    I_pc    = pc;
    tick();
  endtask

  initial begin
    rst = 1'b1; I_valid = 1'b1; I_instr = 32'hFFF00093; I_pc = '0;
    I_flush = 1'b0; I_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", O_valid, 0);
    chk("rst_count", O_count, 0);
    chk("rst_ready", O_ready, 0);
    chk("rst_imm", O_imm, 0);
    chk("rst_pc", O_pc, 0);
    rst = 1'b0; I_valid = 1'b0;
    #1;
    chk("ready_after_rst", O_ready, 1);

    // Streaming decode, I_ready held high.
    send(32'hFFF00093, 32'h100);
    chk("addi_valid", O_valid, 1);
    chk("addi_rd", O_rd, 1);
    chk("addi_fmt", O_fmt, 1);
    chk("addi_regwrite", O_regwrite, 1);
    chk("addi_imm", O_imm, 32'hFFFFFFFF);
    chk("addi_imm_zext", z_imm, 32'h00000FFF);
    chk("addi_funct7", O_funct7, 0);
    chk("addi_pc", O_pc, 32'h100);
    chk("addi_count", O_count, 0);
    send(32'hFE000EE3, 32'h104);
    chk("beq_branch", O_branch, 1);
    chk("beq_fmt", O_fmt, 3);
    chk("beq_imm", O_imm, 32'hFFFFFFFC);
    chk("beq_imm_zext", z_imm, 32'h00001FFC);
    chk("beq_regwrite", O_regwrite, 0);
    chk("beq_count", O_count, 1);
    send(32'h001000EF, 32'h108);
    chk("jal_jump", O_jump, 1);
    chk("jal_fmt", O_fmt, 5);
    chk("jal_imm", O_imm, 32'h00000800);
    chk("jal_rd", O_rd, 1);
    chk("jal_count", O_count, 2);
    send(32'hFF80A103, 32'h10C);
    chk("lw_flags", {O_mread, O_load, O_regwrite, O_mwrite}, 4'b1110);
    chk("lw_imm", O_imm, 32'hFFFFFFF8);
    chk("lw_rs1_rd", {O_rs1, O_rd}, {5'd1, 5'd2});
    send(32'h0020A623, 32'h110);
    chk("sw_flags", {O_mwrite, O_regwrite, O_mread}, 3'b100);
    chk("sw_imm", O_imm, 32'h0000000C);
    chk("sw_fmt_rs2", {O_fmt, O_rs2}, {3'd2, 5'd2});
    send(32'h123450B7, 32'h114);
    chk("lui_imm", O_imm, 32'h12345000);
    chk("lui_fmt", O_fmt, 4);
    send(32'h4030D093, 32'h118);
    chk("srai_funct7", O_funct7, 7'h20);
    chk("srai_imm", O_imm, 32'h00000403);
    send(32'h00000000, 32'h11C);
    chk("ill0_illegal", O_illegal, 1);
    chk("ill0_flags", {O_branch, O_jump, O_mread, O_load, O_mwrite, O_regwrite}, 0);
    chk("ill0_fmt", O_fmt, 0);
    send(32'hFFF00090, 32'h120);
    chk("ill_lowbits", O_illegal, 1);
    chk("ill_lowbits_imm", O_imm, 0);
    chk("ill_lowbits_rw_rd", {O_regwrite, O_rd}, {1'b0, 5'd1});
    I_valid = 1'b0;
    tick();
    chk("drain_valid", O_valid, 0);
    chk("drain_count", O_count, 9);

    // Backpressure: A, B fill the buffer, C waits.
    I_ready = 1'b0;
    send(32'hFFF00093, 32'h200);
    chk("bp_a_valid", O_valid, 1);
    chk("bp_one_ready", O_ready, 1);
    send(32'h001000EF, 32'h204);
    chk("bp_full_ready", O_ready, 0);
    chk("bp_a_held", O_pc, 32'h200);
    send(32'hFE000EE3, 32'h208);
    chk("bp_still_full", O_ready, 0);
    chk("bp_a_stable_pc", O_pc, 32'h200);
    chk("bp_a_stable_imm", O_imm, 32'hFFFFFFFF);
    I_ready = 1'b1;
    tick();
    chk("bp_b_out", O_pc, 32'h204);
    chk("bp_ready_back", O_ready, 1);
    chk("bp_count_a", O_count, 10);
    tick();
    chk("bp_c_out", O_pc, 32'h208);
    chk("bp_count_b", O_count, 11);
    I_valid = 1'b0;
    tick();
    chk("bp_count_c", O_count, 12);
    chk("bp_empty", O_valid, 0);

    // Flush while FULL, with an input offered.
    I_ready = 1'b0;
    send(32'hFFF00093, 32'h300);
    send(32'h001000EF, 32'h304);
    chk("fl_full", O_ready, 0);
    I_flush = 1'b1; I_instr = 32'hFE000EE3; I_pc = 32'h308;
    tick();
    chk("fl_valid", O_valid, 0);
    chk("fl_count", O_count, 12);
    chk("fl_ready", O_ready, 1);
    I_flush = 1'b0; I_valid = 1'b0;
    tick();
    chk("fl_dropped", O_valid, 0);

    // Flush in the same cycle as a delivery still counts it.
    I_ready = 1'b1;
    send(32'hFFF00093, 32'h400);
    I_valid = 1'b0; I_flush = 1'b1;
    tick();
    chk("fl_dlv_count", O_count, 13);
    chk("fl_dlv_valid", O_valid, 0);
    I_flush = 1'b0;

    // Reset mid-stream discards the held entry.
    I_ready = 1'b0;
    send(32'hFFF00093, 32'h500);
    chk("mid_valid", O_valid, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", O_valid, 0);
    chk("mid_rst_count", O_count, 0);

    // 17 back-to-back deliveries; the 4-bit counter wraps to 1.
    rst = 1'b0; I_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(32'hFFF00093, 32'h600 + 32'(i * 4));
    I_valid = 1'b0;
    tick();
    chk("wrap_count16", O_count, 17);
    chk("wrap_count4", w_count, 1);
    chk("wrap_empty", O_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
